// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider controller.
// Dout layout: remainder in the upper half, quotient in the lower.
package div_ctrl_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  localparam int REM_HI = 2*DIV_DATA_W-1;
  localparam int REM_LO = DIV_DATA_W;
  localparam int QUO_HI = DIV_DATA_W-1;
  localparam int QUO_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle between the execute stage, the divider IPs and div_ctrl.
// slave = controller side, master = stage/IP side.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
);

  logic              req_valid;
  logic              req_signed;
  logic              req_mod;
  logic [DATA_W-1:0] req_dividend;
  logic [DATA_W-1:0] req_divisor;
  logic              flush;
  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic              result_ack;
  logic              busy;

  logic              s_dividend_tvalid;
  logic              s_divisor_tvalid;
  logic              ip_sel;
  logic [DATA_W-1:0] s_dividend_tdata;
  logic [DATA_W-1:0] s_divisor_tdata;

  logic sd_dividend_tready;
  logic sd_divisor_tready;
  logic ud_dividend_tready;
  logic ud_divisor_tready;

  logic                sd_dout_tvalid;
  logic [2*DATA_W-1:0] sd_dout_tdata;
  logic                ud_dout_tvalid;
  logic [2*DATA_W-1:0] ud_dout_tdata;

  logic [CNT_W-1:0] last_lat;

  modport slave (
    input  req_valid, req_signed, req_mod,
    input  req_dividend, req_divisor,
    input  flush, result_ack,
    input  sd_dividend_tready, sd_divisor_tready,
    input  ud_dividend_tready, ud_divisor_tready,
    input  sd_dout_tvalid, sd_dout_tdata,
    input  ud_dout_tvalid, ud_dout_tdata,
    output result_valid, result, busy,
    output s_dividend_tvalid, s_divisor_tvalid,
    output ip_sel,
    output s_dividend_tdata, s_divisor_tdata,
    output last_lat
  );

  modport master (
    output req_valid, req_signed, req_mod,
    output req_dividend, req_divisor,
    output flush, result_ack,
    output sd_dividend_tready, sd_divisor_tready,
    output ud_dividend_tready, ud_divisor_tready,
    output sd_dout_tvalid, sd_dout_tdata,
    output ud_dout_tvalid, ud_dout_tdata,
    input  result_valid, result, busy,
    input  s_dividend_tvalid, s_divisor_tvalid,
    input  ip_sel,
    input  s_dividend_tdata, s_divisor_tdata,
    input  last_lat
  );

endinterface

// File: rtl/div_chan_hs.sv
// One AXI-stream input channel: holds tvalid until its handshake.
// done covers both an earlier handshake and one happening this cycle.
module div_chan_hs (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tready,
  output logic tvalid,
  output logic done
);

  logic sent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tvalid <= 1'b0;
      sent   <= 1'b0;
    end else if (start) begin
      tvalid <= 1'b1;
      sent   <= 1'b0;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
      sent   <= 1'b1;
    end
  end

  assign done = sent | (tvalid & tready);

endmodule

// File: rtl/div_ctrl.sv
// Sequences the signed/unsigned divider IPs for the execute stage.
// Holds the selected result until consumed; tracks divide latency.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic      clk,
  input  logic      reset,
  div_ctrl_if.slave bus
);

  state_t state, state_n;

  logic [DATA_W-1:0]   dvd_q;
  logic [DATA_W-1:0]   dvs_q;
  logic [DATA_W-1:0]   res_q;
  logic                sel_q;
  logic                mod_q;
  logic                drop_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    lat_q;
  logic [CNT_W-1:0]    cnt_inc;

  logic                accept;
  logic                capture;
  logic                kill;
  logic                dvd_rdy;
  logic                dvs_rdy;
  logic                dvd_vld;
  logic                dvs_vld;
  logic                dvd_done;
  logic                dvs_done;
  logic                dout_vld;
  logic [2*DATA_W-1:0] dout;

  assign dvd_rdy  = sel_q ? bus.sd_dividend_tready
                          : bus.ud_dividend_tready;
  assign dvs_rdy  = sel_q ? bus.sd_divisor_tready
                          : bus.ud_divisor_tready;
  assign dout_vld = sel_q ? bus.sd_dout_tvalid
                          : bus.ud_dout_tvalid;
  assign dout     = sel_q ? bus.sd_dout_tdata
                          : bus.ud_dout_tdata;
  assign kill     = drop_q | bus.flush;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  div_chan_hs u_dvd (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (dvd_rdy),
    .tvalid (dvd_vld),
    .done   (dvd_done)
  );

  div_chan_hs u_dvs (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .tready (dvs_rdy),
    .tvalid (dvs_vld),
    .done   (dvs_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (dvd_done && dvs_done) state_n = WAIT;
      end
      WAIT: begin
        if (dout_vld) begin
          capture = 1'b1;
          state_n = kill ? IDLE : DONE;
        end
      end
      DONE: begin
        if (bus.result_ack || bus.flush) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      sel_q  <= 1'b0;
      mod_q  <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      lat_q  <= '0;
    end else begin
      if (accept) begin
        dvd_q  <= bus.req_dividend;
        dvs_q  <= bus.req_divisor;
        sel_q  <= bus.req_signed;
        mod_q  <= bus.req_mod;
        drop_q <= 1'b0;
        cnt_q  <= '0;
      end else if (state == ISSUE || state == WAIT) begin
        cnt_q <= cnt_inc;
        if (bus.flush) drop_q <= 1'b1;
      end
      // a flushed op still drains the IP but leaves no trace
      if (capture && !kill) begin
        res_q <= mod_q ? dout[DATA_W +: DATA_W]
                       : dout[0 +: DATA_W];
        lat_q <= cnt_inc;
      end
    end
  end

  assign bus.result_valid      = (state == DONE);
  assign bus.result            = res_q;
  assign bus.busy              = (state != IDLE);
  assign bus.s_dividend_tvalid = dvd_vld;
  assign bus.s_divisor_tvalid  = dvs_vld;
  assign bus.ip_sel            = sel_q;
  assign bus.s_dividend_tdata  = dvd_q;
  assign bus.s_divisor_tdata   = dvs_q;
  assign bus.last_lat          = lat_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider IPs plus a scoreboard
// of hand-computed results popped by an independent monitor.
module tb_div_ctrl;

  localparam int SD_LAT = 8;
  localparam int UD_LAT = 6;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_ctrl_if #(.DATA_W(32), .CNT_W(6)) bus ();

  div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   noise = 1'b0;

  int dvd_hi = 0, dvs_hi = 0, sdq_hi = 0, rv_hi = 0;
  int b_dvd, b_dvs, b_sdq, b_rv;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // divider IP models: dout follows the completing handshake by LAT
  initial begin
    int cyc;
    logic [31:0] s_a, s_b, u_a, u_b;
    bit s_ga, s_gb, u_ga, u_gb;
    int s_due, u_due;
    logic signed [31:0] sa, sb;
    logic [31:0] qq, rr;
    cyc = 0;
    s_ga = 0; s_gb = 0; u_ga = 0; u_gb = 0;
    s_due = -1; u_due = -1;
    s_a = '0; s_b = '0; u_a = '0; u_b = '0;
    bus.sd_dout_tvalid = 1'b0;
    bus.ud_dout_tvalid = 1'b0;
    bus.sd_dout_tdata  = '0;
    bus.ud_dout_tdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        s_ga = 0; s_gb = 0; u_ga = 0; u_gb = 0;
        s_due = -1; u_due = -1;
      end else begin
        if (bus.s_dividend_tvalid && bus.ip_sel &&
            bus.sd_dividend_tready) begin
          s_a = bus.s_dividend_tdata; s_ga = 1;
        end
        if (bus.s_divisor_tvalid && bus.ip_sel &&
            bus.sd_divisor_tready) begin
          s_b = bus.s_divisor_tdata; s_gb = 1;
        end
        if (bus.s_dividend_tvalid && !bus.ip_sel &&
            bus.ud_dividend_tready) begin
          u_a = bus.s_dividend_tdata; u_ga = 1;
        end
        if (bus.s_divisor_tvalid && !bus.ip_sel &&
            bus.ud_divisor_tready) begin
          u_b = bus.s_divisor_tdata; u_gb = 1;
        end
        if (s_ga && s_gb) begin
          s_due = cyc + SD_LAT; s_ga = 0; s_gb = 0;
        end
        if (u_ga && u_gb) begin
          u_due = cyc + UD_LAT; u_ga = 0; u_gb = 0;
        end
      end
      @(negedge clk);
      if (noise) begin
        bus.sd_dout_tvalid = 1'($urandom_range(0, 1));
        bus.ud_dout_tvalid = 1'($urandom_range(0, 1));
        bus.sd_dout_tdata  = {$urandom, $urandom};
        bus.ud_dout_tdata  = {$urandom, $urandom};
      end else begin
        bus.sd_dout_tvalid = (s_due == cyc + 1);
        bus.ud_dout_tvalid = (u_due == cyc + 1);
        bus.sd_dout_tdata  = {$urandom, $urandom};
        bus.ud_dout_tdata  = {$urandom, $urandom};
        if (s_due == cyc + 1) begin
          sa = s_a; sb = s_b;
          qq = sa / sb; rr = sa % sb;
          bus.sd_dout_tdata = {rr, qq};
        end
        if (u_due == cyc + 1) begin
          qq = u_a / u_b; rr = u_a % u_b;
          bus.ud_dout_tdata = {rr, qq};
        end
      end
    end
  end

  // AXI hold rules and per-cycle activity counters
  initial begin
    bit pv_d, pv_s;
    logic [31:0] pd_d, pd_s;
    logic rd_d, rd_s;
    pv_d = 0; pv_s = 0; pd_d = '0; pd_s = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        pv_d = 0; pv_s = 0;
      end else begin
        if (pv_d)
          check("dvd_hold",
                {bus.s_dividend_tvalid, bus.s_dividend_tdata},
                {1'b1, pd_d});
        if (pv_s)
          check("dvs_hold",
                {bus.s_divisor_tvalid, bus.s_divisor_tdata},
                {1'b1, pd_s});
        rd_d = bus.ip_sel ? bus.sd_dividend_tready
                          : bus.ud_dividend_tready;
        rd_s = bus.ip_sel ? bus.sd_divisor_tready
                          : bus.ud_divisor_tready;
        pv_d = bus.s_dividend_tvalid && !rd_d;
        pv_s = bus.s_divisor_tvalid && !rd_s;
        pd_d = bus.s_dividend_tdata;
        pd_s = bus.s_divisor_tdata;
        if (bus.s_dividend_tvalid) dvd_hi++;
        if (bus.s_divisor_tvalid) dvs_hi++;
        if ((bus.s_dividend_tvalid || bus.s_divisor_tvalid)
            && bus.ip_sel) sdq_hi++;
        if (bus.result_valid) rv_hi++;
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t cur;
    bit rv_prev;
    rv_prev = 0;
    cur.res = '0; cur.lat = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rv_prev = 0;
      end else begin
        if (bus.result_valid && !rv_prev) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got %h required none",
                     bus.result);
          end else begin
            cur = q.pop_front();
            check("result", bus.result, cur.res);
            check("last_lat", bus.last_lat, cur.lat);
          end
        end else if (bus.result_valid) begin
          check("result_hold", bus.result, cur.res);
        end
        rv_prev = bus.result_valid;
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy required idle");
    end
  endtask

  task automatic issue(input bit sg, input bit md,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit has_exp,
                       input logic [31:0] er, input logic [5:0] el);
    exp_t e;
    wait_idle();
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_signed   = sg;
    bus.req_mod      = md;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    b_dvd = dvd_hi; b_dvs = dvs_hi;
    b_sdq = sdq_hi; b_rv  = rv_hi;
    if (has_exp) begin
      e.res = er; e.lat = el;
      q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rv(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rv_timeout: got 0 required 1");
    end
  endtask

  task automatic finish(input int hold, input bit nz);
    bit ok;
    wait_rv(ok);
    if (ok) begin
      noise = nz;
      repeat (hold) @(negedge clk);
      noise = 1'b0;
      bus.result_ack = 1'b1;
      @(negedge clk);
      bus.result_ack = 1'b0;
      check("rv_after_ack", bus.result_valid, 0);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_ctl", {bus.busy, bus.result_valid, bus.ip_sel,
                      bus.s_dividend_tvalid, bus.s_divisor_tvalid},
          0);
    check("rst_result", bus.result, 0);
    check("rst_tdata", {bus.s_dividend_tdata, bus.s_divisor_tdata},
          0);
    check("rst_lat", bus.last_lat, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 0; bus.req_signed = 0; bus.req_mod = 0;
    bus.req_dividend = '0; bus.req_divisor = '0;
    bus.flush = 0; bus.result_ack = 0;
    bus.sd_dividend_tready = 1; bus.sd_divisor_tready = 1;
    bus.ud_dividend_tready = 1; bus.ud_divisor_tready = 1;
    #22;
    check_reset_outs();
    @(negedge clk);
    reset = 1'b0;

    // signed 7/2 quotient, result held across 3 cycles
    issue(1, 0, 32'd7, 32'd2, 1, 32'h3, 6'd9);
    finish(3, 0);
    check("t1_dvd_cycles", dvd_hi - b_dvd, 1);
    check("t1_dvs_cycles", dvs_hi - b_dvs, 1);

    issue(1, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 6'd9);
    finish(0, 0);
    issue(1, 0, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 6'd9);
    finish(0, 0);

    issue(0, 0, 32'hFFFF_FFFF, 32'd16, 1, 32'h0FFF_FFFF, 6'd7);
    finish(0, 0);
    check("t3_sd_tvalid", sdq_hi - b_sdq, 0);
    issue(0, 1, 32'hFFFF_FFFF, 32'd16, 1, 32'h0000_000F, 6'd7);
    finish(0, 0);
    check("t3_sd_tvalid_mod", sdq_hi - b_sdq, 0);

    // divisor ready three cycles late
    bus.ud_divisor_tready = 0;
    issue(0, 0, 32'd100, 32'd7, 1, 32'd14, 6'd10);
    repeat (3) @(negedge clk);
    bus.ud_divisor_tready = 1;
    finish(0, 0);
    check("t4_dvd_cycles", dvd_hi - b_dvd, 1);
    check("t4_dvs_cycles", dvs_hi - b_dvs, 4);

    // flush in the second WAIT cycle
    issue(1, 0, 32'd7, 32'd2, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    repeat (5) @(negedge clk);
    check("t5_busy_before_dout", bus.busy, 1);
    @(negedge clk);
    check("t5_busy_after_dout", bus.busy, 0);
    check("t5_rv_cycles", rv_hi - b_rv, 0);
    check("t5_lat_kept", bus.last_lat, 10);
    issue(0, 1, 32'd100, 32'd7, 1, 32'd2, 6'd7);
    finish(0, 0);

    // ack withheld while dout inputs toggle
    issue(1, 1, 32'd7, 32'd2, 1, 32'd1, 6'd9);
    finish(5, 1);
    check("t6_lat_kept", bus.last_lat, 9);

    // latency counter saturates
    bus.ud_divisor_tready = 0;
    issue(0, 0, 32'd50, 32'd5, 1, 32'd10, 6'd63);
    repeat (70) @(negedge clk);
    bus.ud_divisor_tready = 1;
    finish(0, 0);
    check("sat_dvs_cycles", dvs_hi - b_dvs, 71);

    // reset in the middle of WAIT
    issue(1, 0, 32'd100, 32'd7, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_outs();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(0, 1, 32'hFFFF_FFFF, 32'd16, 1, 32'h0000_000F, 6'd7);
    finish(0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
